// File: rtl/rotaryctl_multi.sv
`default_nettype none
// ============================================================================
// Module  : rotaryctl_multi
// Brief   : Multi-channel quadrature encoder decoder with debounce, position
//           counters and an Avalon-MM register/interrupt interface.
// Revision: 1.0
// ============================================================================
module rotaryctl_multi #(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 16,
    parameter int DEBOUNCE = 1000,
    parameter int WRAP     = 1
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [2*NUM_CH-1:0]   rotary_in,
    output logic [NUM_CH-1:0]     rotary_cw,
    output logic [NUM_CH-1:0]     rotary_ccw,
    input  logic [3:0]            avs_address,
    input  logic                  avs_read,
    input  logic                  avs_write,
    input  logic [31:0]           avs_writedata,
    output logic [31:0]           avs_readdata,
    output logic                  irq
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CW1  = 3'd1,
        ST_CW2  = 3'd2,
        ST_CW3  = 3'd3,
        ST_CCW1 = 3'd4,
        ST_CCW2 = 3'd5,
        ST_CCW3 = 3'd6
    } state_t;

    localparam int               C_NB       = 2 * NUM_CH;
    localparam logic [15:0]      C_DEB_LAST = 16'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] C_POS_MAX  = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] C_POS_MIN  = {1'b1, {(CNT_W-1){1'b0}}};

    logic [C_NB-1:0]             sync1_q, sync2_q, deb_q, deb_d;
    logic [C_NB-1:0][15:0]       cnt_q, cnt_d;
    state_t                      state_q [NUM_CH];
    state_t                      state_d [NUM_CH];
    logic [NUM_CH-1:0]           cw_evt, ccw_evt;
    logic [NUM_CH-1:0][CNT_W-1:0] pos_q, pos_d;
    logic [NUM_CH-1:0]           cw_st_q, cw_st_d, ccw_st_q, ccw_st_d;
    logic [NUM_CH-1:0]           irq_en_q, irq_en_d;
    logic [NUM_CH-1:0]           rotary_cw_q, rotary_ccw_q;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        irq_q;
    logic                        w_wr_status, w_wr_irq_en;
    logic                        w_unused;

    assign w_wr_status = avs_write && (avs_address == 4'd8);
    assign w_wr_irq_en = avs_write && (avs_address == 4'd9);
    assign w_unused    = ^avs_writedata;

    // A bit is accepted only after it has differed from the held value for
    // DEBOUNCE consecutive cycles; any agreement in between restarts the count.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int b = 0; b < C_NB; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (cnt_q[b] == C_DEB_LAST) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    cnt_d[b] = cnt_q[b] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        logic [1:0] code;
        code    = 2'b11;
        cw_evt  = '0;
        ccw_evt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            state_d[k] = state_q[k];
            code       = deb_q[2*k +: 2];
            case (state_q[k])
                ST_IDLE: begin
                    if (code == 2'b01)      state_d[k] = ST_CW1;
                    else if (code == 2'b10) state_d[k] = ST_CCW1;
                end
                ST_CW1: begin
                    if (code == 2'b00)      state_d[k] = ST_CW2;
                    else if (code != 2'b01) state_d[k] = ST_IDLE;
                end
                ST_CW2: begin
                    if (code == 2'b10)      state_d[k] = ST_CW3;
                    else if (code == 2'b01) state_d[k] = ST_CW1;
                    else if (code != 2'b00) state_d[k] = ST_IDLE;
                end
                ST_CW3: begin
                    if (code == 2'b11) begin
                        state_d[k] = ST_IDLE;
                        cw_evt[k]  = 1'b1;
                    end else if (code == 2'b00) state_d[k] = ST_CW2;
                    else if (code != 2'b10)     state_d[k] = ST_IDLE;
                end
                ST_CCW1: begin
                    if (code == 2'b00)      state_d[k] = ST_CCW2;
                    else if (code != 2'b10) state_d[k] = ST_IDLE;
                end
                ST_CCW2: begin
                    if (code == 2'b01)      state_d[k] = ST_CCW3;
                    else if (code == 2'b10) state_d[k] = ST_CCW1;
                    else if (code != 2'b00) state_d[k] = ST_IDLE;
                end
                ST_CCW3: begin
                    if (code == 2'b11) begin
                        state_d[k] = ST_IDLE;
                        ccw_evt[k] = 1'b1;
                    end else if (code == 2'b00) state_d[k] = ST_CCW2;
                    else if (code != 2'b01)     state_d[k] = ST_IDLE;
                end
                default: state_d[k] = ST_IDLE;
            endcase
        end
    end

    // Host write to a position register overrides a coincident step.
    always_comb begin
        pos_d = pos_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (avs_write && (avs_address == 4'(k))) begin
                pos_d[k] = avs_writedata[CNT_W-1:0];
            end else if (cw_evt[k]) begin
                if (!(WRAP == 0 && pos_q[k] == C_POS_MAX)) pos_d[k] = pos_q[k] + 1'b1;
            end else if (ccw_evt[k]) begin
                if (!(WRAP == 0 && pos_q[k] == C_POS_MIN)) pos_d[k] = pos_q[k] - 1'b1;
            end
        end
    end

    always_comb begin
        cw_st_d  = (cw_st_q  & ~(w_wr_status ? avs_writedata[NUM_CH-1:0]  : '0)) | cw_evt;
        ccw_st_d = (ccw_st_q & ~(w_wr_status ? avs_writedata[8 +: NUM_CH] : '0)) | ccw_evt;
        irq_en_d = w_wr_irq_en ? avs_writedata[NUM_CH-1:0] : irq_en_q;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (avs_read) begin
            readdata_d = '0;
            if (avs_address == 4'd8) begin
                readdata_d[NUM_CH-1:0]  = cw_st_q;
                readdata_d[8 +: NUM_CH] = ccw_st_q;
            end else if (avs_address == 4'd9) begin
                readdata_d[NUM_CH-1:0] = irq_en_q;
            end else begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (avs_address == 4'(k)) readdata_d = 32'($signed(pos_q[k]));
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            deb_q        <= '1;
            cnt_q        <= '0;
            for (int k = 0; k < NUM_CH; k++) state_q[k] <= ST_IDLE;
            pos_q        <= '0;
            cw_st_q      <= '0;
            ccw_st_q     <= '0;
            irq_en_q     <= '0;
            rotary_cw_q  <= '0;
            rotary_ccw_q <= '0;
            readdata_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            sync1_q      <= rotary_in;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            cnt_q        <= cnt_d;
            for (int k = 0; k < NUM_CH; k++) state_q[k] <= state_d[k];
            pos_q        <= pos_d;
            cw_st_q      <= cw_st_d;
            ccw_st_q     <= ccw_st_d;
            irq_en_q     <= irq_en_d;
            rotary_cw_q  <= cw_evt;
            rotary_ccw_q <= ccw_evt;
            readdata_q   <= readdata_d;
            irq_q        <= |(irq_en_q & (cw_st_q | ccw_st_q));
        end
    end

    assign rotary_cw    = rotary_cw_q;
    assign rotary_ccw   = rotary_ccw_q;
    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_rotaryctl_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_rotaryctl_multi
// Brief   : Scoreboard bench for rotaryctl_multi (wrapping and saturating DUTs).
// Revision: 1.0
// ============================================================================
module tb_rotaryctl_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  pins   [2];
    logic [1:0]  cw_o   [2];
    logic [1:0]  ccw_o  [2];
    logic [3:0]  addr   [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] wd     [2];
    logic [31:0] rdata  [2];
    logic        irq_o  [2];
    logic        rd_v_q [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_evt [$];
    logic [31:0] exp_rd  [$];
    string       rd_name [$];
    logic [31:0] mon_e;
    string       mon_nm;
    int          mon_c;

    always #5 clk = ~clk;

    // DUT 0 wraps with a 16-bit counter, DUT 1 saturates with an 8-bit counter.
    rotaryctl_multi #(.NUM_CH(2), .CNT_W(16), .DEBOUNCE(4), .WRAP(1)) u_dut_wrap (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(pins[0]),
        .rotary_cw(cw_o[0]), .rotary_ccw(ccw_o[0]),
        .avs_address(addr[0]), .avs_read(rd[0]), .avs_write(wr[0]),
        .avs_writedata(wd[0]), .avs_readdata(rdata[0]), .irq(irq_o[0])
    );

    rotaryctl_multi #(.NUM_CH(2), .CNT_W(8), .DEBOUNCE(4), .WRAP(0)) u_dut_sat (
        .clk_clk(clk), .reset_reset_n(rst_n), .rotary_in(pins[1]),
        .rotary_cw(cw_o[1]), .rotary_ccw(ccw_o[1]),
        .avs_address(addr[1]), .avs_read(rd[1]), .avs_write(wr[1]),
        .avs_writedata(wd[1]), .avs_readdata(rdata[1]), .irq(irq_o[1])
    );

    // Event code = dut*100 + channel*10 + (0 cw / 1 ccw).
    task automatic chk_evt(input int code);
        n_tests++;
        if (exp_evt.size() == 0) begin
            n_fail++;
            $display("FAIL pulse: unexpected pulse code %0d, none expected", code);
        end else begin
            mon_c = exp_evt.pop_front();
            if (mon_c != code) begin
                n_fail++;
                $display("FAIL pulse: got code %0d, expected %0d", code, mon_c);
            end
        end
    endtask

    always @(posedge clk) begin
        rd_v_q[0] <= rd[0];
        rd_v_q[1] <= rd[1];
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (cw_o[d][ch] === 1'b1)  chk_evt(d*100 + ch*10);
                if (ccw_o[d][ch] === 1'b1) chk_evt(d*100 + ch*10 + 1);
            end
            if (rd_v_q[d] === 1'b1) begin
                n_tests++;
                if (exp_rd.size() == 0) begin
                    n_fail++;
                    $display("FAIL read dut%0d: unexpected data %h", d, rdata[d]);
                end else begin
                    mon_e  = exp_rd.pop_front();
                    mon_nm = rd_name.pop_front();
                    if (rdata[d] !== mon_e) begin
                        n_fail++;
                        $display("FAIL %s: got %h, expected %h", mon_nm, rdata[d], mon_e);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_read(input int d, input logic [3:0] a, input logic [31:0] e, input string nm);
        exp_rd.push_back(e);
        rd_name.push_back(nm);
        addr[d] = a;
        rd[d]   = 1'b1;
        tick(1);
        rd[d]   = 1'b0;
        tick(1);
    endtask

    task automatic do_write(input int d, input logic [3:0] a, input logic [31:0] v);
        addr[d] = a;
        wd[d]   = v;
        wr[d]   = 1'b1;
        tick(1);
        wr[d]   = 1'b0;
        tick(1);
    endtask

    task automatic set_code(input int d, input int ch, input logic [1:0] code, input int n);
        pins[d][2*ch +: 2] = code;
        tick(n);
    endtask

    function automatic logic [1:0] step_code(input bit ccw, input int s);
        case (s)
            0:       step_code = ccw ? 2'b10 : 2'b01;
            1:       step_code = 2'b00;
            2:       step_code = ccw ? 2'b01 : 2'b10;
            default: step_code = 2'b11;
        endcase
    endfunction

    // Full detent on the channels in chm; optional host write lands exactly on
    // the event edge (2 sync + 4 debounce + 1 cycles after the final code).
    task automatic turn(input int d, input logic [1:0] chm, input logic [1:0] ccwm,
                        input bit wen, input logic [3:0] wa, input logic [31:0] wv);
        for (int s = 0; s < 4; s++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (chm[ch]) begin
                    if (s == 3) exp_evt.push_back(d*100 + ch*10 + int'(ccwm[ch]));
                    pins[d][2*ch +: 2] = step_code(ccwm[ch], s);
                end
            end
            if (s == 3 && wen) begin
                tick(6);
                addr[d] = wa;
                wd[d]   = wv;
                wr[d]   = 1'b1;
                tick(1);
                wr[d]   = 1'b0;
                tick(3);
            end else begin
                tick(10);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pins[d] = 4'hF; addr[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; wd[d] = '0;
        end
        tick(3);
        for (int d = 0; d < 2; d++) begin
            check("reset_readdata", rdata[d], 32'h0);
            check("reset_irq", {31'b0, irq_o[d]}, 32'h0);
            check("reset_pulses", {28'b0, cw_o[d], ccw_o[d]}, 32'h0);
        end
        rst_n = 1'b1;
        tick(3);
        do_read(0, 4'd0, 32'h0, "pos0_reset");
        do_read(0, 4'd8, 32'h0, "status_reset");
        do_read(0, 4'd9, 32'h0, "irqen_reset");

        turn(0, 2'b01, 2'b00, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd0, 32'h1, "pos0_after_cw");
        do_read(0, 4'd8, 32'h1, "status_cw0");
        do_write(0, 4'd8, 32'h0303);
        do_read(0, 4'd8, 32'h0, "status_cleared");

        turn(0, 2'b10, 2'b10, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd1, 32'hFFFF_FFFF, "pos1_ccw_from_0");
        do_read(0, 4'd8, 32'h200, "status_ccw1");
        do_write(0, 4'd8, 32'h0303);

        for (int i = 0; i < 5; i++) begin
            set_code(0, 0, 2'b01, 2);
            set_code(0, 0, 2'b11, 2);
        end
        tick(20);
        do_read(0, 4'd0, 32'h1, "pos0_after_bounce");

        set_code(0, 0, 2'b01, 10); set_code(0, 0, 2'b11, 10);
        set_code(0, 0, 2'b00, 10); set_code(0, 0, 2'b11, 10);
        set_code(0, 0, 2'b01, 10); set_code(0, 0, 2'b00, 10); set_code(0, 0, 2'b11, 10);
        do_read(0, 4'd0, 32'h1, "pos0_no_event");
        do_read(0, 4'd8, 32'h0, "status_no_event");
        turn(0, 2'b01, 2'b00, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd0, 32'h2, "pos0_after_idle_recovery");

        do_write(0, 4'd8, 32'h0303);
        do_write(0, 4'd9, 32'h1);
        do_read(0, 4'd9, 32'h1, "irqen_readback");
        check("irq_idle", {31'b0, irq_o[0]}, 32'h0);
        turn(0, 2'b01, 2'b00, 1'b0, 4'd0, 32'h0);
        check("irq_after_cw", {31'b0, irq_o[0]}, 32'h1);
        turn(0, 2'b01, 2'b00, 1'b1, 4'd8, 32'h1);
        do_read(0, 4'd8, 32'h1, "status_set_wins");
        check("irq_held", {31'b0, irq_o[0]}, 32'h1);
        do_read(0, 4'd0, 32'h4, "pos0_four");
        do_write(0, 4'd8, 32'h1);
        tick(1);
        check("irq_cleared", {31'b0, irq_o[0]}, 32'h0);

        turn(0, 2'b01, 2'b00, 1'b1, 4'd0, 32'h1234);
        do_read(0, 4'd0, 32'h1234, "pos0_write_wins");

        do_write(0, 4'd0, 32'h7FFF);
        turn(0, 2'b01, 2'b00, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd0, 32'hFFFF_8000, "pos0_wrap_max");
        turn(0, 2'b01, 2'b01, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd0, 32'h0000_7FFF, "pos0_wrap_min");

        do_write(0, 4'd8, 32'h0303);
        turn(0, 2'b11, 2'b10, 1'b0, 4'd0, 32'h0);
        do_read(0, 4'd0, 32'hFFFF_8000, "pos0_simul");
        do_read(0, 4'd1, 32'hFFFF_FFFE, "pos1_simul");
        do_read(0, 4'd8, 32'h201, "status_simul");
        do_read(0, 4'd5, 32'h0, "unmapped5");
        do_read(0, 4'd2, 32'h0, "unmapped2");

        do_write(1, 4'd1, 32'hFFFF_FF80);
        do_read(1, 4'd1, 32'hFFFF_FF80, "sat_pos1_min");
        turn(1, 2'b10, 2'b10, 1'b0, 4'd0, 32'h0);
        do_read(1, 4'd1, 32'hFFFF_FF80, "sat_pos1_hold_min");
        do_write(1, 4'd0, 32'h0000_017F);
        do_read(1, 4'd0, 32'h0000_007F, "sat_pos0_truncate");
        turn(1, 2'b01, 2'b00, 1'b0, 4'd0, 32'h0);
        do_read(1, 4'd0, 32'h0000_007F, "sat_pos0_hold_max");
        do_read(1, 4'd8, 32'h201, "sat_status");

        set_code(0, 0, 2'b01, 10); set_code(0, 0, 2'b00, 10); set_code(0, 0, 2'b10, 10);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        do_read(0, 4'd0, 32'h0, "pos0_after_midreset");
        set_code(0, 0, 2'b11, 20);
        do_read(0, 4'd8, 32'h0, "status_after_midreset");
        tick(5);

        n_tests++;
        if (exp_evt.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: %0d outstanding, expected 0", exp_evt.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rotaryctl_multi.md
ROTARYCTL_MULTI -- requirements
Module: rotaryctl_multi

Interface
REQ-001 Parameter NUM_CH, default 2, number of encoder channels (legal 1..8).
REQ-002 Parameter CNT_W, default 16, width of each signed position counter (legal 8..32).
REQ-003 Parameter DEBOUNCE, default 1000, clock cycles an input bit must hold stable before acceptance (legal 1..65535).
REQ-004 Parameter WRAP, default 1; 1 = position wraps two's-complement, 0 = position saturates.
REQ-005 clk_clk  in  1  single clock, all logic rising-edge.
REQ-006 reset_reset_n  in  1  asynchronous active-low reset.
REQ-007 rotary_in  in  2*NUM_CH  raw encoder pins; channel k = bits [2k+1:2k] = {A,B}, asynchronous.
REQ-008 rotary_cw  out  NUM_CH  one-cycle pulse per completed clockwise detent, per channel.
REQ-009 rotary_ccw  out  NUM_CH  one-cycle pulse per completed counter-clockwise detent, per channel.
REQ-010 avs_address  in  4  register index.
REQ-011 avs_read  in  1  read strobe.
REQ-012 avs_write  in  1  write strobe.
REQ-013 avs_writedata  in  32  write data.
REQ-014 avs_readdata  out  32  read data, valid one cycle after avs_read.
REQ-015 irq  out  1  level interrupt, high while any enabled sticky event bit is set.

Function
REQ-016 Each rotary_in bit SHALL pass a 2-flop synchronizer, then a debouncer that updates its output only after the synchronized value differs from it for DEBOUNCE consecutive cycles; any bounce restarts the count.
REQ-017 Each channel SHALL run a decoder FSM with states IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3 on debounced {A,B}.
REQ-018 Transitions: IDLE-01->CW1-00->CW2-10->CW3-11->IDLE with cw event; IDLE-10->CCW1-00->CCW2-01->CCW3-11->IDLE with ccw event.
REQ-019 A step back to the previous code in a sequence SHALL return to the previous state (IDLE if at CW1/CCW1), no event.
REQ-020 Any other code change (including both bits changing together) SHALL return to IDLE with no event; IDLE holds on 11 only, other codes in IDLE hold without event.
REQ-021 Event pulse SHALL assert the cycle after the debounced code reaches 11; latency pin-to-pulse = 2 + DEBOUNCE + 1 cycles.
REQ-022 cw event increments position[k] by 1, ccw decrements by 1, in the same cycle as the pulse.
REQ-023 WRAP=1: max+1 -> min, min-1 -> max. WRAP=0: hold at 2^(CNT_W-1)-1 / -2^(CNT_W-1); pulse still issued.
REQ-024 Register map: address k (k<NUM_CH) = position[k] sign-extended to 32 bits, R/W; address 8 = STATUS; address 9 = IRQ_EN; other addresses read 0, writes ignored.
REQ-025 STATUS bits [k] = sticky cw event, [8+k] = sticky ccw event; write-1-to-clear; unused bits read 0.
REQ-026 IRQ_EN bits [NUM_CH-1:0] enable per channel; irq = OR over k of IRQ_EN[k] AND (STATUS[k] OR STATUS[8+k]), registered (one cycle after status change).
REQ-027 Host write to position[k] in the same cycle as a step event on k: write value SHALL win, step discarded; pulse and sticky bit still asserted.
REQ-028 STATUS clear and set of the same bit in the same cycle: set SHALL win.
REQ-029 Write to position takes effect the next cycle; writedata truncated to CNT_W bits.
REQ-030 Channels SHALL be fully independent; simultaneous events on multiple channels all recorded.

Reset
REQ-031 On reset_reset_n low, asynchronously: positions 0, FSMs IDLE, debounced values 11, synchronizers 11, debounce counters 0, STATUS 0, IRQ_EN 0, rotary_cw 0, rotary_ccw 0, avs_readdata 0, irq 0.
REQ-032 Reset mid-sequence SHALL abandon the sequence with no event; after release a fresh full sequence is required.

Verification
REQ-033 DEBOUNCE=4, ch0 pins 11->01->00->10->11 each held 10 cycles -> one rotary_cw[0] pulse, position[0] reads 1, STATUS=0x001.
REQ-034 ch1 full CCW sequence from position 0, WRAP=1, CNT_W=8 -> position[1] reads 0xFFFFFFFF; WRAP=0 at -128 -> stays -128, ccw pulse still seen.
REQ-035 ch0 bit A toggling every 2 cycles for 20 cycles (DEBOUNCE=4) then returning to 1 -> no pulse, position unchanged.
REQ-036 ch0 11->01->11 -> no event; 11->00 direct -> FSM IDLE, no event.
REQ-037 IRQ_EN=0x1, cw on ch0 -> irq high; write STATUS 0x001 same cycle as new ch0 event -> bit stays set, irq stays high.
REQ-038 Write 0x1234 to address 0 same cycle as ch0 cw event -> position[0] reads 0x1234, rotary_cw[0] pulses.
